// File: rtl/puf_mux_scan.sv
// PUF cell scanner: selects one of N_IN raw cells, waits a settle time, samples
// (optionally 3x with majority vote) and packs OUT_W bits into a handshaked word.
module puf_mux_scan #(
   parameter int unsigned N_IN     = 128,
   parameter int unsigned SEL_W    = $clog2(N_IN),
   parameter int unsigned OUT_W    = 32,
   parameter int unsigned SETTLE_W = 8
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic [N_IN-1:0]     i_D,
   input  logic                i_Start,
   input  logic [SEL_W-1:0]    i_Base,
   input  logic [SEL_W-1:0]    i_Stride,
   input  logic [SETTLE_W-1:0] i_Settle,
   input  logic                i_Vote,
   output logic [SEL_W-1:0]    o_Sel,
   output logic                o_Busy,
   output logic [OUT_W-1:0]    o_Resp,
   output logic                o_Valid,
   input  logic                i_Ready,
   output logic                o_Err
);

   localparam int unsigned    BIT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [SEL_W:0] N_EXT    = (SEL_W+1)'(N_IN);
   localparam logic [SEL_W-1:0] N_LO   = SEL_W'(N_IN);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(OUT_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_ADVANCE,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic [1:0]          smp_q, smp_d;
   logic [1:0]          ones_q, ones_d;
   logic [SEL_W-1:0]    stride_q, stride_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic                vote_q, vote_d;
   logic [OUT_W-1:0]    resp_q, resp_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   logic                cur;
   logic                base_bad;
   logic [SEL_W-1:0]    stride_red;
   logic [SEL_W-1:0]    sel_sum;
   logic                sel_cy;
   logic [SEL_W-1:0]    sel_next;

   assign cur      = i_D[sel_q];
   assign base_bad = ({1'b0, i_Base} >= N_EXT);

   // Both operands stay below N_IN after reduction, so one conditional subtract
   // completes the modulo; the low SEL_W bits of the difference are exact.
   assign stride_red = ({1'b0, i_Stride} >= N_EXT) ? (i_Stride - N_LO) : i_Stride;
   assign {sel_cy, sel_sum} = {1'b0, sel_q} + {1'b0, stride_q};
   assign sel_next = ({sel_cy, sel_sum} >= N_EXT) ? (sel_sum - N_LO) : sel_sum;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      bit_d    = bit_q;
      cnt_d    = cnt_q;
      smp_d    = smp_q;
      ones_d   = ones_q;
      stride_d = stride_q;
      settle_d = settle_q;
      vote_d   = vote_q;
      resp_d   = resp_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_Start) begin
               stride_d = stride_red;
               settle_d = i_Settle;
               vote_d   = i_Vote;
               if (base_bad) begin
                  err_d = 1'b1;
               end else begin
                  sel_d   = i_Base;
                  busy_d  = 1'b1;
                  bit_d   = '0;
                  smp_d   = '0;
                  ones_d  = '0;
                  cnt_d   = i_Settle;
                  state_d = (i_Settle == '0) ? S_SAMPLE : S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SETTLE_W'(1)) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (!vote_q) begin
               resp_d[bit_q] = cur;
               state_d       = S_ADVANCE;
            end else if (smp_q == 2'd2) begin
               resp_d[bit_q] = (ones_q == 2'd2) || ((ones_q == 2'd1) && cur);
               smp_d         = '0;
               ones_d        = '0;
               state_d       = S_ADVANCE;
            end else begin
               smp_d  = smp_q + 2'd1;
               ones_d = ones_q + {1'b0, cur};
            end
         end
         S_ADVANCE: begin
            if (bit_q == LAST_BIT) begin
               valid_d = 1'b1;
               state_d = S_DONE;
            end else begin
               bit_d   = bit_q + 1'b1;
               sel_d   = sel_next;
               cnt_d   = settle_q;
               state_d = (settle_q == '0) ? S_SAMPLE : S_SETTLE;
            end
         end
         S_DONE: begin
            if (i_Ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q  <= S_IDLE;
         sel_q    <= '0;
         bit_q    <= '0;
         cnt_q    <= '0;
         smp_q    <= '0;
         ones_q   <= '0;
         stride_q <= '0;
         settle_q <= '0;
         vote_q   <= 1'b0;
         resp_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         bit_q    <= bit_d;
         cnt_q    <= cnt_d;
         smp_q    <= smp_d;
         ones_q   <= ones_d;
         stride_q <= stride_d;
         settle_q <= settle_d;
         vote_q   <= vote_d;
         resp_q   <= resp_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign o_Sel   = sel_q;
   assign o_Busy  = busy_q;
   assign o_Resp  = resp_q;
   assign o_Valid = valid_q;
   assign o_Err   = err_q;

endmodule

// File: tb/tb_puf_mux_scan.sv
// Scoreboard bench for puf_mux_scan: a power-of-two instance (N_IN=128) and a
// non-power-of-two instance (N_IN=100), both with 8-bit responses.
module tb_puf_mux_scan;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] d_a;
   logic [99:0]  d_b;
   logic         start_a, start_b;
   logic [6:0]   base, stride;
   logic [7:0]   settle;
   logic         vote, rdy;
   logic [6:0]   sel_a, sel_b;
   logic         busy_a, busy_b, valid_a, valid_b, err_a, err_b;
   logic [7:0]   resp_a, resp_b;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0] resp;
      int         cyc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   sq_a[$];
   int   sq_b[$];

   puf_mux_scan #(.N_IN(128), .OUT_W(8), .SETTLE_W(8)) dut_a (
      .i_Clk(clk), .i_Rst(rst), .i_D(d_a), .i_Start(start_a), .i_Base(base),
      .i_Stride(stride), .i_Settle(settle), .i_Vote(vote), .o_Sel(sel_a),
      .o_Busy(busy_a), .o_Resp(resp_a), .o_Valid(valid_a), .i_Ready(rdy), .o_Err(err_a)
   );

   puf_mux_scan #(.N_IN(100), .OUT_W(8), .SETTLE_W(8)) dut_b (
      .i_Clk(clk), .i_Rst(rst), .i_D(d_b), .i_Start(start_b), .i_Base(base),
      .i_Stride(stride), .i_Settle(settle), .i_Vote(vote), .o_Sel(sel_b),
      .o_Busy(busy_b), .o_Resp(resp_b), .o_Valid(valid_b), .i_Ready(rdy), .o_Err(err_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   task automatic push_a(input logic [7:0] r, input int c);
      exp_t e;
      e.resp = r; e.cyc = c;
      q_a.push_back(e);
   endtask

   task automatic push_b(input logic [7:0] r, input int c);
      exp_t e;
      e.resp = r; e.cyc = c;
      q_b.push_back(e);
   endtask

   // Pulse start for one cycle; c0 is the cycle count of the accepting edge.
   task automatic go(input logic use_b, output int c0);
      @(negedge clk);
      if (use_b) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      c0 = cyc;
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 500 && (q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b); i++)
         @(negedge clk);
      if (i >= 500) chk("drain_timeout", 1, 0);
      @(negedge clk);
   endtask

   // Monitors: pop expectations when a response appears, track select changes.
   logic       seen_a = 1'b0, seen_b = 1'b0;
   logic       bprev_a = 1'b0, bprev_b = 1'b0;
   logic [6:0] sprev_a = '0, sprev_b = '0;

   always @(negedge clk) begin
      exp_t e;
      if (valid_a && !seen_a) begin
         if (q_a.size() == 0) chk("unexpected_valid_a", 1, 0);
         else begin
            e = q_a.pop_front();
            chk("resp_a", resp_a, e.resp);
            chk("latency_a", cyc, e.cyc);
         end
      end
      seen_a = valid_a;
      if (busy_a && (!bprev_a || sel_a != sprev_a) && sq_a.size() != 0)
         chk("sel_a", sel_a, sq_a.pop_front());
      bprev_a = busy_a;
      sprev_a = sel_a;
   end

   always @(negedge clk) begin
      exp_t e;
      if (valid_b && !seen_b) begin
         if (q_b.size() == 0) chk("unexpected_valid_b", 1, 0);
         else begin
            e = q_b.pop_front();
            chk("resp_b", resp_b, e.resp);
            chk("latency_b", cyc, e.cyc);
         end
      end
      seen_b = valid_b;
      if (busy_b && (!bprev_b || sel_b != sprev_b)) begin
         chk("sel_range_b", sel_b < 7'd100, 1);
         if (sq_b.size() != 0) chk("sel_b", sel_b, sq_b.pop_front());
      end
      bprev_b = busy_b;
      sprev_b = sel_b;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int k, r;
      logic [2:0] pat [4];
      pat[0] = 3'b101; pat[1] = 3'b010; pat[2] = 3'b110; pat[3] = 3'b001;

      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; rdy = 1'b1;
      base = '0; stride = '0; settle = '0; vote = 1'b0;
      d_a = (128'h1 << 127) | 128'h5;
      d_b = '0;
      d_b[98] = 1'b1; d_b[1] = 1'b1; d_b[7] = 1'b1; d_b[19] = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_a", {sel_a, busy_a, resp_a, valid_a, err_a}, '0);
      chk("reset_b", {sel_b, busy_b, resp_b, valid_b, err_b}, '0);
      rst = 1'b0;

      // Power-of-two wrap
      base = 7'd126; stride = 7'd1; settle = 8'd0; vote = 1'b0;
      foreach (sq_a[i]) sq_a.delete();
      sq_a = '{126, 127, 0, 1, 2, 3, 4, 5};
      go(1'b0, c0); push_a(8'h16, c0 + 16);
      drain();

      // Non-power-of-two wrap, settle=1; stride 103 reduces to 3
      base = 7'd98; stride = 7'd3; settle = 8'd1;
      sq_b = '{98, 1, 4, 7, 10, 13, 16, 19};
      go(1'b1, c0); push_b(8'h8B, c0 + 24);
      drain();
      stride = 7'd103;
      sq_b = '{98, 1, 4, 7, 10, 13, 16, 19};
      go(1'b1, c0); push_b(8'h8B, c0 + 24);
      drain();
      stride = 7'd127;
      go(1'b1, c0); push_b(8'h01, c0 + 24);
      drain();
      base = 7'd19; stride = 7'd0; settle = 8'd0;
      go(1'b1, c0); push_b(8'hFF, c0 + 16);
      drain();

      // Invalid base
      base = 7'd100;
      go(1'b1, c0);
      chk("err_pulse_b", {err_b, busy_b}, 2'b10);
      @(negedge clk);
      chk("err_clear_b", {err_b, busy_b}, 2'b00);
      repeat (40) @(negedge clk);
      chk("err_no_valid_b", {valid_b, busy_b}, 2'b00);

      // Majority vote, settle=2: cell 5 driven per sample cycle
      d_a = '0; base = 7'd5; stride = 7'd0; settle = 8'd2; vote = 1'b1;
      go(1'b0, c0); push_a(8'h55, c0 + 48);
      for (int j = 1; j <= 48; j++) begin
         k = (j - 1) / 6;
         r = (j - 1) % 6;
         d_a[5] = (r >= 2 && r <= 4) ? pat[k % 4][r - 2] : 1'b0;
         @(negedge clk);
      end
      drain();

      // Backpressure with start held during the stall
      d_a = (128'h1 << 127) | 128'h5;
      base = 7'd0; stride = 7'd1; settle = 8'd0; vote = 1'b0; rdy = 1'b0;
      go(1'b0, c0); push_a(8'h05, c0 + 16);
      for (k = 0; k < 100 && !valid_a; k++) @(negedge clk);
      if (k >= 100) chk("bp_valid_timeout", 1, 0);
      base = 7'd1; start_a = 1'b1;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         chk("bp_hold", {valid_a, busy_a, resp_a}, {2'b11, 8'h05});
      end
      rdy = 1'b1;
      @(negedge clk);
      chk("bp_transfer", {valid_a, busy_a}, 2'b00);
      @(negedge clk);
      start_a = 1'b0;
      c0 = cyc;
      chk("bp_accept", busy_a, 1'b1);
      push_a(8'h02, c0 + 16);
      drain();

      // Reset mid-scan at bit 3, then a clean scan
      base = 7'd126; stride = 7'd1;
      go(1'b0, c0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midscan_reset_a", {sel_a, busy_a, resp_a, valid_a, err_a}, '0);
      rst = 1'b0;
      go(1'b0, c0); push_a(8'h16, c0 + 16);
      drain();

      chk("scoreboard_empty", q_a.size() + q_b.size() + sq_a.size() + sq_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
